// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first.
// Result, carry-out and signed overflow are registered and held between operations.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int DW = DIGIT + 1;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_adder: need WIDTH >= 2, DIGIT >= 1, WIDTH %% DIGIT == 0");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_c;
   logic             r_amsb;
   logic             r_bmsb;
   logic [CW-1:0]    r_cnt;
   logic [DW-1:0]    w_dsum;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   // Operands shift right so the active digit always sits in the low bits;
   // the result digit enters the accumulator from the top.
   assign w_dsum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + DW'(r_c);
   assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
   assign w_last    = (r_cnt == CW'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_c      <= 1'b0;
         r_amsb   <= 1'b0;
         r_bmsb   <= 1'b0;
         r_cnt    <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
         r_a    <= a;
         r_b    <= sub ? ~b : b;
         r_c    <= sub;
         r_amsb <= a[WIDTH-1];
         r_bmsb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
         r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
         r_a   <= r_a >> DIGIT;
         r_b   <= r_b >> DIGIT;
         r_c   <= w_dsum[DIGIT];
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            sum      <= w_acc_nxt;
            carry    <= w_dsum[DIGIT];
            overflow <= (r_amsb == r_bmsb) && (w_acc_nxt[WIDTH-1] != r_amsb);
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 with DIGIT=1 (main), 4 and 8.
module tb_serial_adder;

   localparam int N = 8;

   logic       clk;
   logic       rst;
   logic       start, sub;
   logic [7:0] a, b;
   logic       busy, done, carry, overflow;
   logic [7:0] sum;
   logic       start4, sub4;
   logic [7:0] a4, b4;
   logic       busy4, done4, carry4, overflow4;
   logic [7:0] sum4;
   logic       start8, sub8;
   logic [7:0] a8, b8;
   logic       busy8, done8, carry8, overflow8;
   logic [7:0] sum8;

   int         n_chk;
   int         n_fail;
   logic [7:0] exp_sum;
   logic       exp_c, exp_o;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow));

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .overflow(overflow4));

   serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(overflow8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      #2;
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_main: busy=%b done=%b sum=%h c=%b o=%b, want all 0", busy, done, sum, carry, overflow);
      end
      n_chk++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_digit: busy4=%b sum4=%h busy8=%b sum8=%h, want 0", busy4, sum4, busy8, sum8);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_sum = 8'h00; exp_c = 1'b0; exp_o = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                         input logic [7:0] es, input logic ec, input logic eo);
      int   cyc;
      int   nbusy;
      logic seen;
      logic held;
      @(negedge clk);
      start = 1'b1; a = ia; b = ib; sub = isub;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~ia; b = ia ^ ib; sub = ~isub;
      cyc = 0; nbusy = 0; seen = 1'b0; held = 1'b1;
      while (!seen && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (busy) nbusy++;
         if (done) seen = 1'b1;
         else if (sum !== exp_sum || carry !== exp_c || overflow !== exp_o) held = 1'b0;
      end
      n_chk++;
      if (!seen || cyc != N + 1) begin
         n_fail++;
         $display("FAIL %s latency: done seen=%b at cycle %0d, want cycle %0d", nm, seen, cyc, N + 1);
      end
      n_chk++;
      if (sum !== es) begin n_fail++; $display("FAIL %s sum: got %h want %h", nm, sum, es); end
      n_chk++;
      if (carry !== ec) begin n_fail++; $display("FAIL %s carry: got %b want %b", nm, carry, ec); end
      n_chk++;
      if (overflow !== eo) begin n_fail++; $display("FAIL %s overflow: got %b want %b", nm, overflow, eo); end
      n_chk++;
      if (!held) begin n_fail++; $display("FAIL %s hold: outputs changed before done, want %h/%b/%b", nm, exp_sum, exp_c, exp_o); end
      n_chk++;
      if (nbusy != N + 1) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, nbusy, N + 1); end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_done: done=%b busy=%b, want 0 0", nm, done, busy);
      end
      exp_sum = es; exp_c = ec; exp_o = eo;
   endtask

   task automatic test_add();
      run_op("add_3c_41", 8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
   endtask

   task automatic test_sub();
      run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      int         ndone;
      int         d1, d2;
      logic [7:0] s1, s2;
      logic       c1, o1, c2, o2;
      logic       b10, b11;
      ndone = 0; d1 = 0; d2 = 0; s1 = 8'h00; s2 = 8'h00;
      c1 = 1'b0; o1 = 1'b0; c2 = 1'b0; o2 = 1'b0; b10 = 1'b1; b11 = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
      @(posedge clk);
      for (int cyc = 1; cyc <= 22; cyc++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) begin d1 = cyc; s1 = sum; c1 = carry; o1 = overflow; end
            if (ndone == 2) begin d2 = cyc; s2 = sum; c2 = carry; o2 = overflow; end
         end
         if (cyc == 10) b10 = busy;
         if (cyc == 11) b11 = busy;
         if (cyc == 10) begin
            a = 8'h30; b = 8'h50; sub = 1'b1;
         end else begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
         end
         if (cyc >= 11) start = 1'b0;
      end
      n_chk++;
      if (ndone != 2) begin n_fail++; $display("FAIL b2b done_count: got %0d want 2", ndone); end
      n_chk++;
      if (d1 != 9 || d2 != 19) begin n_fail++; $display("FAIL b2b done_cycles: got %0d,%0d want 9,19", d1, d2); end
      n_chk++;
      if (s1 !== 8'h46 || c1 !== 1'b0 || o1 !== 1'b0) begin
         n_fail++; $display("FAIL b2b op1: got %h/%b/%b want 46/0/0", s1, c1, o1);
      end
      n_chk++;
      if (s2 !== 8'hE0 || c2 !== 1'b0 || o2 !== 1'b0) begin
         n_fail++; $display("FAIL b2b op2: got %h/%b/%b want e0/0/0", s2, c2, o2);
      end
      n_chk++;
      if (b10 !== 1'b0 || b11 !== 1'b1) begin
         n_fail++; $display("FAIL b2b issue_gap: busy c10=%b c11=%b want 0 1", b10, b11);
      end
      exp_sum = 8'hE0; exp_c = 1'b0; exp_o = 1'b0;
   endtask

   task automatic test_abort();
      int ndone;
      ndone = 0;
      @(negedge clk);
      start = 1'b1; a = 8'h3C; b = 8'h41; sub = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: busy=%b done=%b sum=%h c=%b o=%b, want all 0", busy, done, sum, carry, overflow);
      end
      #1 rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      n_chk++;
      if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", ndone); end
      exp_sum = 8'h00; exp_c = 1'b0; exp_o = 1'b0;
      run_op("after_abort_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
   endtask

   task automatic test_digit4(input string nm, input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                              input logic [7:0] es, input logic ec, input logic eo);
      int   cyc;
      logic seen;
      @(negedge clk);
      start4 = 1'b1; a4 = ia; b4 = ib; sub4 = isub;
      @(posedge clk);
      #1 start4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (done4) seen = 1'b1;
      end
      n_chk++;
      if (!seen || cyc != 3) begin n_fail++; $display("FAIL %s latency: seen=%b cycle %0d want 3", nm, seen, cyc); end
      n_chk++;
      if (sum4 !== es || carry4 !== ec || overflow4 !== eo) begin
         n_fail++; $display("FAIL %s result: got %h/%b/%b want %h/%b/%b", nm, sum4, carry4, overflow4, es, ec, eo);
      end
      @(negedge clk);
   endtask

   task automatic test_digit8();
      int   cyc;
      logic seen;
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h3C; b8 = 8'h41; sub8 = 1'b0;
      @(posedge clk);
      #1 start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (done8) seen = 1'b1;
      end
      n_chk++;
      if (!seen || cyc != 2) begin n_fail++; $display("FAIL d8 latency: seen=%b cycle %0d want 2", seen, cyc); end
      n_chk++;
      if (sum8 !== 8'h7D || carry8 !== 1'b0 || overflow8 !== 1'b0) begin
         n_fail++; $display("FAIL d8 result: got %h/%b/%b want 7d/0/0", sum8, carry8, overflow8);
      end
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1;
      start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
      start4 = 1'b0; sub4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
      start8 = 1'b0; sub8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      exp_sum = 8'h00; exp_c = 1'b0; exp_o = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_abort();
      test_digit4("d4_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      test_digit4("d4_sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      test_digit8();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
